cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//   Shares the single common data bus (CDB) between the EXE and MEM result producers.
//   Each producer pushes completed results (phys map, arch reg, value, ROB index) into a private FIFO.
//   A round-robin arbiter drains one result per cycle onto the registered CDB.
//   The CDB feeds ID/rename wakeup and the ROB complete port.
//   Flush from the ROB discards all buffered results.
// PARAMETERS
//   DATA_W     32  result value width
//   MAP_W      6   physical register map width
//   REG_W      5   architectural register index width
//   ROB_W      6   ROB instruction number width
//   FIFO_DEPTH 2   entries per producer FIFO (power of 2, >=2)
// PORTS
//   CLK            in   1       clock, rising edge
//   RESET          in   1       asynchronous, active-low reset
//   flush          in   1       synchronous flush from ROB
//   exe_valid      in   1       EXE result present
//   exe_ready      out  1       EXE FIFO can accept
//   exe_map        in   MAP_W   EXE dest physical map
//   exe_reg        in   REG_W   EXE dest arch reg
//   exe_val        in   DATA_W  EXE result value
//   exe_rob        in   ROB_W   EXE ROB instruction number
//   mem_valid      in   1       MEM result present
//   mem_ready      out  1       MEM FIFO can accept
//   mem_map/mem_reg/mem_val/mem_rob  in  MAP_W/REG_W/DATA_W/ROB_W  MEM result, as EXE
//   cdb_valid      out  1       broadcast valid this cycle
//   cdb_map        out  MAP_W   broadcast physical map
//   cdb_reg        out  REG_W   broadcast arch reg
//   cdb_val        out  DATA_W  broadcast value
//   cdb_rob        out  ROB_W   broadcast ROB instruction number
//   cdb_src        out  1       0=EXE, 1=MEM winner
//   conflict_cnt   out  16      saturating count of contended cycles
// BEHAVIOUR
//   Reset (RESET=0, async):
//   - both FIFOs empty; cdb_* = 0; cdb_valid = 0.
//   - last_grant = MEM, so EXE wins the first tie.
//   - conflict_cnt = 0; exe_ready/mem_ready forced 0 while RESET is low.
//   Enqueue:
//   - An entry is written at an edge where x_valid & x_ready. Otherwise producer must hold data.
//   - x_ready = (count_x < FIFO_DEPTH), computed from registered count only.
//   - A full FIFO shows ready=0 even in a cycle where it pops (no same-cycle pass-through).
//   Arbitration, combinational on FIFO heads, once per cycle:
//   - Only one FIFO non-empty: grant it.
//   - Both non-empty: grant the source != last_grant; on the edge, last_grant <= winner.
//   - Neither non-empty: no grant; last_grant is unchanged.
//   Output register, loaded every edge:
//   - cdb_valid <= grant. On grant, cdb_* <= winner's head and the winner pops.
//   - With no grant, cdb_map/reg/val/rob/src hold their last value; only cdb_valid drops.
//   - Latency: result handshaken at edge k drives the CDB in the cycle after edge k+1, if uncontended.
//   - Throughput is 1 result per cycle total.
//   FIFO pointers:
//   - log2(FIFO_DEPTH)-bit rd/wr pointers wrap modulo FIFO_DEPTH.
//   - count is 0..FIFO_DEPTH, width log2(FIFO_DEPTH)+1.
//   - Push and pop in the same cycle leave count unchanged.
//   Flush (sampled high at an edge):
//   - Both FIFOs cleared; cdb_valid <= 0; same-cycle pushes and grants are discarded.
//   - last_grant and conflict_cnt are retained.
//   - x_ready is valid again the next cycle.
//   conflict_cnt:
//   - +1 on each edge where both FIFOs are non-empty and flush=0.
//   - Saturates at 16'hFFFF; clears only on reset.
//   Reset mid-operation: all state returns immediately to the reset values; in-flight results are lost.
// TESTING
//   1 Single EXE push (map=6'd5, reg=5'd3, val=32'hDEADBEEF, rob=6'd1) at edge 0 -> cdb_valid=1, cdb_src=0, fields match in cycle after edge 1, cdb_valid=0 after.
//   2 EXE and MEM push same edge after reset -> EXE broadcast first, MEM next cycle.
//     conflict_cnt=1; second tie is granted to EXE (alternation).
//   3 MEM holds valid for 4 cycles while EXE is idle, FIFO_DEPTH=2 -> mem_ready stays 1.
//     Exactly 4 MEM broadcasts in order, back-to-back, no loss or duplication.
//   4 Both sources stream continuously for 8 cycles -> CDB alternates EXE/MEM every cycle.
//     Each x_ready toggles low when full; conflict_cnt increments each contended cycle; no FIFO overflow.
//   5 Fill both FIFOs, assert flush with a new EXE push the same edge -> next cycle cdb_valid=0.
//     Both FIFOs empty, ready=1, flushed EXE entry never appears on the CDB.
//   6 Drop RESET low asynchronously between edges while both FIFOs are full -> cdb_valid=0 immediately.
//     Ready=0 while RESET is low; after release, ready=1 and conflict_cnt=0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two producer result FIFOs drained round-robin onto one registered broadcast bus.

// cdb_fifo: generic synchronous FIFO with a synchronous flush.
// Latency: a pushed entry is visible at the head on the next cycle.
// Backpressure: push_rdy comes only from the registered count, so a full FIFO refuses a push even in a cycle where it pops.
module cdb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         flush,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         nonempty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    // Ready is held low for the whole reset assertion.
    assign push_rdy = RESET & (count < CNT_FULL);
    assign nonempty = (count != '0);
    assign head_dat = mem[rd_ptr];
    assign do_push  = push_vld & push_rdy & ~flush;
    assign do_pop   = pop & nonempty & ~flush;

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end
endmodule

// cdb_arbiter: per-producer FIFOs, round-robin grant, registered CDB broadcast.
// Latency: result accepted at edge k is broadcast in the cycle after edge k+1 when uncontended.
// Backpressure: exe_ready/mem_ready reflect each FIFO's registered occupancy; flush empties both.
module cdb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int MAP_W      = 6,
    parameter int REG_W      = 5,
    parameter int ROB_W      = 6,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              flush,
    input  logic              exe_valid,
    output logic              exe_ready,
    input  logic [MAP_W-1:0]  exe_map,
    input  logic [REG_W-1:0]  exe_reg,
    input  logic [DATA_W-1:0] exe_val,
    input  logic [ROB_W-1:0]  exe_rob,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [MAP_W-1:0]  mem_map,
    input  logic [REG_W-1:0]  mem_reg,
    input  logic [DATA_W-1:0] mem_val,
    input  logic [ROB_W-1:0]  mem_rob,
    output logic              cdb_valid,
    output logic [MAP_W-1:0]  cdb_map,
    output logic [REG_W-1:0]  cdb_reg,
    output logic [DATA_W-1:0] cdb_val,
    output logic [ROB_W-1:0]  cdb_rob,
    output logic              cdb_src,
    output logic [15:0]       conflict_cnt
);
    typedef struct packed {
        logic [MAP_W-1:0]  map;
        logic [REG_W-1:0]  arch;
        logic [DATA_W-1:0] val;
        logic [ROB_W-1:0]  rob;
    } res_t;

    localparam int RES_W = $bits(res_t);

    res_t exe_in_dat;
    res_t mem_in_dat;
    res_t exe_head;
    res_t mem_head;
    res_t win_dat;
    logic exe_ne;
    logic mem_ne;
    logic grant;
    logic win_mem;
    logic last_grant;  // 1 = MEM won most recently

    assign exe_in_dat = '{map: exe_map, arch: exe_reg, val: exe_val, rob: exe_rob};
    assign mem_in_dat = '{map: mem_map, arch: mem_reg, val: mem_val, rob: mem_rob};

    cdb_fifo #(.W(RES_W), .DEPTH(FIFO_DEPTH)) u_exe_fifo (
        .CLK      (CLK),
        .RESET    (RESET),
        .flush    (flush),
        .push_vld (exe_valid),
        .push_rdy (exe_ready),
        .push_dat (exe_in_dat),
        .pop      (grant & ~win_mem),
        .head_dat (exe_head),
        .nonempty (exe_ne)
    );

    cdb_fifo #(.W(RES_W), .DEPTH(FIFO_DEPTH)) u_mem_fifo (
        .CLK      (CLK),
        .RESET    (RESET),
        .flush    (flush),
        .push_vld (mem_valid),
        .push_rdy (mem_ready),
        .push_dat (mem_in_dat),
        .pop      (grant & win_mem),
        .head_dat (mem_head),
        .nonempty (mem_ne)
    );

    // On a tie the source that did not win last time gets the bus.
    assign grant   = exe_ne | mem_ne;
    assign win_mem = mem_ne & (~exe_ne | ~last_grant);
    assign win_dat = win_mem ? mem_head : exe_head;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cdb_valid  <= 1'b0;
            cdb_map    <= '0;
            cdb_reg    <= '0;
            cdb_val    <= '0;
            cdb_rob    <= '0;
            cdb_src    <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            cdb_valid <= grant & ~flush;
            if (grant && !flush) begin
                cdb_map    <= win_dat.map;
                cdb_reg    <= win_dat.arch;
                cdb_val    <= win_dat.val;
                cdb_rob    <= win_dat.rob;
                cdb_src    <= win_mem;
                last_grant <= win_mem;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            conflict_cnt <= '0;
        end else if (exe_ne && mem_ne && !flush && conflict_cnt != 16'hFFFF) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: queue-based reference model plus a decoupled negedge monitor.
module tb_cdb_arbiter;
    localparam int DEPTH = 2;

    logic        CLK;
    logic        RESET;
    logic        flush;
    logic        exe_valid, exe_ready, mem_valid, mem_ready;
    logic [5:0]  exe_map, mem_map, cdb_map;
    logic [4:0]  exe_reg, mem_reg, cdb_reg;
    logic [31:0] exe_val, mem_val, cdb_val;
    logic [5:0]  exe_rob, mem_rob, cdb_rob;
    logic        cdb_valid, cdb_src;
    logic [15:0] conflict_cnt;

    typedef struct {
        logic [5:0]  map;
        logic [4:0]  arch;
        logic [31:0] val;
        logic [5:0]  rob;
    } res_t;

    typedef struct {
        logic [5:0]  map;
        logic [4:0]  arch;
        logic [31:0] val;
        logic [5:0]  rob;
        logic        src;
        int          cyc;
    } exp_t;

    res_t q_exe[$];
    res_t q_mem[$];
    exp_t sb[$];
    bit   m_last;
    int   m_cnt;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   acc_e, acc_m, win;
    res_t r;
    exp_t e;

    cdb_arbiter dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .flush        (flush),
        .exe_valid    (exe_valid),
        .exe_ready    (exe_ready),
        .exe_map      (exe_map),
        .exe_reg      (exe_reg),
        .exe_val      (exe_val),
        .exe_rob      (exe_rob),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_map      (mem_map),
        .mem_reg      (mem_reg),
        .mem_val      (mem_val),
        .mem_rob      (mem_rob),
        .cdb_valid    (cdb_valid),
        .cdb_map      (cdb_map),
        .cdb_reg      (cdb_reg),
        .cdb_val      (cdb_val),
        .cdb_rob      (cdb_rob),
        .cdb_src      (cdb_src),
        .conflict_cnt (conflict_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each producer is a bounded queue; one result per edge leaves toward the bus.
    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            q_exe.delete();
            q_mem.delete();
            sb.delete();
            m_last = 1'b1;
            m_cnt  = 0;
        end else begin
            cyc++;
            if (flush) begin
                q_exe.delete();
                q_mem.delete();
            end else begin
                acc_e = exe_valid && (q_exe.size() < DEPTH);
                acc_m = mem_valid && (q_mem.size() < DEPTH);
                if (q_exe.size() > 0 && q_mem.size() > 0) begin
                    if (m_cnt < 65535) m_cnt++;
                    win = !m_last;
                end else begin
                    win = (q_mem.size() > 0);
                end
                if (q_exe.size() > 0 || q_mem.size() > 0) begin
                    r = win ? q_mem.pop_front() : q_exe.pop_front();
                    sb.push_back('{r.map, r.arch, r.val, r.rob, win, cyc});
                    m_last = win;
                end
                if (acc_e) q_exe.push_back('{exe_map, exe_reg, exe_val, exe_rob});
                if (acc_m) q_mem.push_back('{mem_map, mem_reg, mem_val, mem_rob});
            end
        end
    end

    always @(negedge CLK) begin
        chk("exe_ready", 32'(exe_ready), 32'(RESET && q_exe.size() < DEPTH));
        chk("mem_ready", 32'(mem_ready), 32'(RESET && q_mem.size() < DEPTH));
        chk("conflict_cnt", 32'(conflict_cnt), m_cnt);
        if (cdb_valid) begin
            if (sb.size() == 0) begin
                chk("cdb_valid_spurious", 32'(cdb_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("cdb_cycle", cyc, e.cyc);
                chk("cdb_src", 32'(cdb_src), 32'(e.src));
                chk("cdb_map", 32'(cdb_map), 32'(e.map));
                chk("cdb_reg", 32'(cdb_reg), 32'(e.arch));
                chk("cdb_val", cdb_val, e.val);
                chk("cdb_rob", 32'(cdb_rob), 32'(e.rob));
            end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            chk("cdb_valid_missing", 32'(cdb_valid), 32'd1);
            sb.delete(0);
        end
    end

    task automatic drive(input bit ev, input bit mv, input bit fl);
        exe_valid = ev;
        mem_valid = mv;
        flush     = fl;
        exe_map   = 6'($urandom);
        exe_reg   = 5'($urandom);
        exe_val   = $urandom;
        exe_rob   = 6'($urandom);
        mem_map   = 6'($urandom);
        mem_reg   = 5'($urandom);
        mem_val   = $urandom;
        mem_rob   = 6'($urandom);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET     = 1'b0;
        flush     = 1'b0;
        exe_valid = 1'b0;
        mem_valid = 1'b0;
        exe_map = '0; exe_reg = '0; exe_val = '0; exe_rob = '0;
        mem_map = '0; mem_reg = '0; mem_val = '0; mem_rob = '0;
        #6;
        chk("reset_cdb_valid", 32'(cdb_valid), 32'd0);
        chk("reset_cdb_val", cdb_val, 32'd0);
        chk("reset_conflict", 32'(conflict_cnt), 32'd0);
        chk("reset_exe_ready", 32'(exe_ready), 32'd0);
        #6 RESET = 1'b1;
        @(posedge CLK);
        #1;

        // Single EXE result with known fields.
        exe_valid = 1'b1;
        exe_map = 6'd5; exe_reg = 5'd3; exe_val = 32'hDEADBEEF; exe_rob = 6'd1;
        @(posedge CLK);
        #1;
        repeat (3) drive(0, 0, 0);

        // Tie after idle, then a second tie to observe alternation.
        drive(1, 1, 0);
        repeat (3) drive(0, 0, 0);
        drive(1, 1, 0);
        repeat (3) drive(0, 0, 0);

        // MEM alone streaming back-to-back.
        repeat (4) drive(0, 1, 0);
        repeat (3) drive(0, 0, 0);

        // Both streaming: FIFOs fill and ready toggles.
        repeat (8) drive(1, 1, 0);
        repeat (6) drive(0, 0, 0);

        // Fill, then flush with a concurrent EXE push.
        repeat (4) drive(1, 1, 0);
        drive(1, 0, 1);
        repeat (3) drive(0, 0, 0);

        // Asynchronous reset between edges with both FIFOs full.
        repeat (4) drive(1, 1, 0);
        #2 RESET = 1'b0;
        #1;
        chk("async_rst_cdb_valid", 32'(cdb_valid), 32'd0);
        chk("async_rst_exe_ready", 32'(exe_ready), 32'd0);
        chk("async_rst_mem_ready", 32'(mem_ready), 32'd0);
        exe_valid = 1'b0;
        mem_valid = 1'b0;
        repeat (2) @(posedge CLK);
        #3 RESET = 1'b1;
        #1;
        chk("post_rst_exe_ready", 32'(exe_ready), 32'd1);
        chk("post_rst_mem_ready", 32'(mem_ready), 32'd1);
        chk("post_rst_conflict", 32'(conflict_cnt), 32'd0);
        @(posedge CLK);
        #1;

        // Randomized traffic with occasional flushes.
        repeat (300) drive($urandom % 4 != 0, $urandom % 3 != 0, $urandom % 25 == 0);
        repeat (6) drive(0, 0, 0);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
